// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types and defaults for the trace capture controller.
// TRACE_AVG_EN selects point averaging instead of stride decimation.
package trace_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int NUM_CH_DEF       = 4;
  localparam int DATA_W_DEF       = 8;
  localparam int ADDR_W_DEF       = 10;
  localparam int AVG_MAX_LOG2_DEF = 4;

  localparam int SLICE_BUS_W = 128;
  localparam int SLICE_MAX_W = 16;

  // Extract channel ch (width dw) from a packed channel bus, ch0 in the LSBs.
  function automatic logic [SLICE_MAX_W-1:0] ch_slice(input logic [SLICE_BUS_W-1:0] bus,
                                                      input int ch, input int dw);
    logic [SLICE_BUS_W-1:0] mask_v;
    mask_v = (SLICE_BUS_W'(1'b1) << dw) - SLICE_BUS_W'(1'b1);
    return SLICE_MAX_W'((bus >> (ch * dw)) & mask_v);
  endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Trace memory write port shared by all channels; the controller drives it as master.
interface trace_capture_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic [NUM_CH-1:0]        w_en;
  logic [ADDR_W-1:0]        w_addr;
  logic [NUM_CH*DATA_W-1:0] w_data;

  modport master (output w_en, w_addr, w_data);
  modport slave  (input  w_en, w_addr, w_data);
endinterface

// File: rtl/trace_capture_ctrl_accum.sv
// Per-channel point accumulator used when TRACE_AVG_EN is defined.
module trace_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12,
  parameter int N_W    = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  input  logic [N_W-1:0]    n,
  output logic [DATA_W-1:0] dout
);
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_s;

  // dout includes the current sample so the point can be written on its last edge.
  assign sum_s = (clr ? {ACC_W{1'b0}} : acc_q) + ACC_W'(din);
  assign dout  = DATA_W'(sum_s >> n);

  // Running sum of the samples of the current point.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= {ACC_W{1'b0}};
    end else if (add) begin
      acc_q <= sum_s;
    end
  end
endmodule

// File: rtl/trace_capture_ctrl.sv
// Multi-channel sensor trace acquisition controller: trigger, delay, strided capture, done/ack.
// Define TRACE_AVG_EN to store 2^n-sample averages instead of decimated samples.
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic                     ack_i,
  input  logic                     trig_i,
  input  logic [15:0]              cfg_offset_i,
  input  logic [ADDR_W:0]          cfg_len_i,
  input  logic [7:0]               cfg_decim_i,
  input  logic [NUM_CH-1:0]        cfg_ch_mask_i,
  input  logic [NUM_CH*DATA_W-1:0] sens_data_i,
  trace_capture_ctrl_if.master     wr,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     retrig_o
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e                   state_q;
  logic                     trig_q, busy_q, done_q, retrig_q;
  logic [15:0]              offset_q, off_q;
  logic [7:0]               per_q, ph_q;
  logic [ADDR_W:0]          len_q, smp_q;
  logic [NUM_CH-1:0]        mask_q, w_en_q;
  logic [ADDR_W-1:0]        w_addr_q;
  logic [NUM_CH*DATA_W-1:0] w_data_q;

  logic                     trig_edge_s, cap_edge_s, strobe_s;
  logic [ADDR_W:0]          len_clamp_s;
  logic [7:0]               per_s, ph_s, ph_nxt_s, strobe_ph_s;
  logic [NUM_CH*DATA_W-1:0] sample_s;

  assign trig_edge_s = trig_i & ~trig_q;
  assign len_clamp_s = (cfg_len_i > DEPTH) ? DEPTH : cfg_len_i;
  // The phase counter only carries meaning in CAPTURE; the first capture edge is phase 0.
  assign ph_s        = (state_q == ST_CAPTURE) ? ph_q : 8'd0;
  assign ph_nxt_s    = (ph_s == per_q - 8'd1) ? 8'd0 : ph_s + 8'd1;
  assign strobe_s    = cap_edge_s & (ph_s == strobe_ph_s);

`ifdef TRACE_AVG_EN
  logic [2:0]               n_s, n_q;
  logic [SLICE_BUS_W-1:0]   sens_ext_s;
  logic                     acc_clr_s;

  assign n_s         = (cfg_decim_i[2:0] > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : cfg_decim_i[2:0];
  assign per_s       = 8'd1 << n_s;
  assign strobe_ph_s = per_q - 8'd1;
  assign sens_ext_s  = SLICE_BUS_W'(sens_data_i);
  assign acc_clr_s   = cap_edge_s & (ph_s == 8'd0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_acc
    trace_accum #(
      .DATA_W (DATA_W),
      .ACC_W  (DATA_W + AVG_MAX_LOG2),
      .N_W    (3)
    ) u_acc (
      .clk  (clk),
      .rstn (rstn),
      .clr  (acc_clr_s),
      .add  (cap_edge_s),
      .din  (DATA_W'(ch_slice(sens_ext_s, c, DATA_W))),
      .n    (n_q),
      .dout (sample_s[c*DATA_W +: DATA_W])
    );
  end

  // Averaging exponent latched on arm.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q <= 3'd0;
    end else if (state_q == ST_IDLE && arm_i && !abort_i) begin
      n_q <= n_s;
    end
  end
`else
  assign per_s       = (cfg_decim_i == 8'd0) ? 8'd1 : cfg_decim_i;
  assign strobe_ph_s = 8'd0;
  assign sample_s    = sens_data_i;
`endif

  // Edges on which sens_data belongs to the trace window.
  always_comb begin
    cap_edge_s = 1'b0;
    case (state_q)
      ST_ARMED:   cap_edge_s = trig_edge_s & (offset_q == 16'd0);
      ST_DELAY:   cap_edge_s = (off_q == 16'd1);
      ST_CAPTURE: cap_edge_s = (smp_q < len_q);
      default:    cap_edge_s = 1'b0;
    endcase
  end

  // Control FSM, counters and registered write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      retrig_q <= 1'b0;
      offset_q <= 16'd0;
      off_q    <= 16'd0;
      per_q    <= 8'd0;
      ph_q     <= 8'd0;
      len_q    <= '0;
      smp_q    <= '0;
      mask_q   <= '0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      trig_q <= trig_i;
      w_en_q <= '0;
      if (cap_edge_s) begin
        ph_q <= ph_nxt_s;
      end
      if (strobe_s && !abort_i) begin
        w_en_q   <= mask_q;
        w_addr_q <= smp_q[ADDR_W-1:0];
        w_data_q <= sample_s;
        smp_q    <= smp_q + 1'b1;
      end
      if (abort_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_i) begin
              len_q    <= len_clamp_s;
              offset_q <= cfg_offset_i;
              per_q    <= per_s;
              mask_q   <= cfg_ch_mask_i;
              retrig_q <= 1'b0;
              smp_q    <= '0;
              if (len_clamp_s == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_ARMED;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_ARMED: begin
            if (trig_edge_s) begin
              off_q <= offset_q;
              if (offset_q == 16'd0) begin
                state_q <= ST_CAPTURE;
              end else begin
                state_q <= ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (trig_edge_s) begin
              retrig_q <= 1'b1;
            end
            off_q <= off_q - 16'd1;
            if (off_q == 16'd1) begin
              state_q <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (trig_edge_s) begin
              retrig_q <= 1'b1;
            end
            // Leave one edge after the last strobe so done follows the final write.
            if (smp_q == len_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (ack_i) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr.w_en   = w_en_q;
  assign wr.w_addr = w_addr_q;
  assign wr.w_data = w_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign retrig_o  = retrig_q;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl; define TRACE_AVG_EN to add the averaging vector.
module tb_trace_capture_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        arm, abort, ack, trig;
  logic [15:0] cfg_offset;
  logic [10:0] cfg_len;
  logic [7:0]  cfg_decim;
  logic [3:0]  cfg_mask;
  logic [31:0] sens_data;
  logic        busy, done, retrig;
  logic        const_mode;
  logic [31:0] const_val;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  en;
  } wr_t;

  wr_t log_q[$];
  int  cyc = 0;
  int  done_cyc;
  int  e0;
  int  n_vec = 0;
  int  n_miss = 0;

  trace_capture_ctrl_if #(.NUM_CH(4), .DATA_W(8), .ADDR_W(10)) wr_if ();

  trace_capture_ctrl #(.NUM_CH(4), .DATA_W(8), .ADDR_W(10), .AVG_MAX_LOG2(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .arm_i         (arm),
    .abort_i       (abort),
    .ack_i         (ack),
    .trig_i        (trig),
    .cfg_offset_i  (cfg_offset),
    .cfg_len_i     (cfg_len),
    .cfg_decim_i   (cfg_decim),
    .cfg_ch_mask_i (cfg_mask),
    .sens_data_i   (sens_data),
    .wr            (wr_if),
    .busy_o        (busy),
    .done_o        (done),
    .retrig_o      (retrig)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramp(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b + 8'd48, b + 8'd32, b + 8'd16, b};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the edge, then new sensor data is applied.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_if.w_en != 4'd0) begin
      w.cyc  = cyc;
      w.addr = wr_if.w_addr;
      w.data = wr_if.w_data;
      w.en   = wr_if.w_en;
      log_q.push_back(w);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    sens_data = const_mode ? const_val : ramp(cyc);
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cyc = -1;
  endtask

  task automatic arm_cfg(input logic [15:0] off, input logic [10:0] len,
                         input logic [7:0] dec, input logic [3:0] mask);
    cfg_offset = off;
    cfg_len    = len;
    cfg_decim  = dec;
    cfg_mask   = mask;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    e0   = cyc;
    trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int bad;
    rstn = 1'b0; arm = 1'b0; abort = 1'b0; ack = 1'b0; trig = 1'b0;
    cfg_offset = 16'd0; cfg_len = 11'd0; cfg_decim = 8'd0; cfg_mask = 4'd0;
    const_mode = 1'b0; const_val = 32'd0; sens_data = ramp(0);
    clear_log();
    repeat (3) tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_retrig", 32'(retrig), 32'd0);
    check_val("rst_wen", 32'(wr_if.w_en), 32'd0);
    check_val("rst_waddr", 32'(wr_if.w_addr), 32'd0);
    check_val("rst_wdata", wr_if.w_data, 32'd0);
    rstn = 1'b1;
    tick();

    // Vector 1: contiguous capture of a ramp from the trigger edge.
    clear_log();
    arm_cfg(16'd0, 11'd8, 8'd1, 4'hF);
    check_val("t1_busy_armed", 32'(busy), 32'd1);
    pulse_trig();
    wait_done("t1", 50);
    check_val("t1_nwr", 32'(log_q.size()), 32'd8);
    for (int k = 0; k < log_q.size() && k < 8; k++) begin
      check_val($sformatf("t1_addr%0d", k), 32'(log_q[k].addr), 32'(k));
      check_val($sformatf("t1_data%0d", k), log_q[k].data, ramp(e0 + k - 1));
      check_val($sformatf("t1_cyc%0d", k), 32'(log_q[k].cyc), 32'(e0 + k));
    end
    check_val("t1_done_cyc", 32'(done_cyc), 32'(e0 + 8));
    check_val("t1_wen_low", 32'(wr_if.w_en), 32'd0);
    check_val("t1_busy_done", 32'(busy), 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("t1_arm_in_done", 32'(done), 32'd1);
    do_ack();
    check_val("t1_ack", 32'(done), 32'd0);

    // Vector 2: offset 5, stride 3.
    clear_log();
    arm_cfg(16'd5, 11'd4, 8'd3, 4'hF);
    pulse_trig();
    wait_done("t2", 50);
    check_val("t2_nwr", 32'(log_q.size()), 32'd4);
    for (int k = 0; k < log_q.size() && k < 4; k++) begin
      check_val($sformatf("t2_cyc%0d", k), 32'(log_q[k].cyc), 32'(e0 + 5 + 3 * k));
      check_val($sformatf("t2_data%0d", k), log_q[k].data, ramp(e0 + 4 + 3 * k));
      check_val($sformatf("t2_addr%0d", k), 32'(log_q[k].addr), 32'(k));
    end
    bad = 0;
    for (int k = 1; k < log_q.size(); k++) if (log_q[k].cyc == log_q[k-1].cyc + 1) bad++;
    check_val("t2_adjacent", 32'(bad), 32'd0);
    check_val("t2_done_cyc", 32'(done_cyc), 32'(e0 + 15));
    do_ack();

    // Vector 3: length above DEPTH is clamped.
    clear_log();
    arm_cfg(16'd0, 11'd2000, 8'd1, 4'hF);
    pulse_trig();
    wait_done("t3", 1100);
    check_val("t3_nwr", 32'(log_q.size()), 32'd1024);
    bad = 0;
    for (int k = 0; k < log_q.size(); k++) if (log_q[k].addr != 10'(k)) bad++;
    check_val("t3_addr_seq", 32'(bad), 32'd0);
    if (log_q.size() > 0) check_val("t3_last_addr", 32'(log_q[log_q.size()-1].addr), 32'd1023);
    check_val("t3_done_cyc", 32'(done_cyc), 32'(e0 + 1024));
    check_val("t3_waddr_hold", 32'(wr_if.w_addr), 32'd1023);
    do_ack();

    // Vector 4: abort mid-capture, then a masked re-capture.
    clear_log();
    arm_cfg(16'd0, 11'd16, 8'd1, 4'hF);
    pulse_trig();
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t4_wen_abort", 32'(wr_if.w_en), 32'd0);
    check_val("t4_busy_abort", 32'(busy), 32'd0);
    check_val("t4_done_abort", 32'(done), 32'd0);
    check_val("t4_nwr_abort", 32'(log_q.size()), 32'd3);
    repeat (3) tick();
    check_val("t4_idle_quiet", 32'(log_q.size()), 32'd3);
    clear_log();
    arm_cfg(16'd0, 11'd2, 8'd1, 4'b0101);
    pulse_trig();
    wait_done("t4b", 20);
    check_val("t4b_nwr", 32'(log_q.size()), 32'd2);
    for (int k = 0; k < log_q.size() && k < 2; k++) begin
      check_val($sformatf("t4b_en%0d", k), 32'(log_q[k].en), 32'h5);
      check_val($sformatf("t4b_data%0d", k), log_q[k].data, ramp(e0 + k - 1));
    end
    do_ack();

    // Vector 5: trigger edge on the arm cycle is ignored; retrig during capture.
    clear_log();
    trig = 1'b1;
    arm_cfg(16'd2, 11'd6, 8'd2, 4'hF);
    tick();
    check_val("t5_still_armed", 32'(busy), 32'd1);
    check_val("t5_no_early_wr", 32'(log_q.size()), 32'd0);
    trig = 1'b0;
    tick();
    pulse_trig();
    check_val("t5_retrig_clear", 32'(retrig), 32'd0);
    repeat (2) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_done("t5", 50);
    check_val("t5_retrig_set", 32'(retrig), 32'd1);
    check_val("t5_nwr", 32'(log_q.size()), 32'd6);
    if (log_q.size() > 0) check_val("t5_first_cyc", 32'(log_q[0].cyc), 32'(e0 + 2));
    do_ack();
    arm_cfg(16'd0, 11'd4, 8'd1, 4'hF);
    check_val("t5_retrig_rearm", 32'(retrig), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Vector 6: zero length goes straight to done; zero decimation acts as 1.
    clear_log();
    arm_cfg(16'd0, 11'd0, 8'd1, 4'hF);
    check_val("t6_len0_done", 32'(done), 32'd1);
    check_val("t6_len0_busy", 32'(busy), 32'd0);
    do_ack();
    check_val("t6_len0_nwr", 32'(log_q.size()), 32'd0);
`ifndef TRACE_AVG_EN
    clear_log();
    arm_cfg(16'd0, 11'd3, 8'd0, 4'hF);
    pulse_trig();
    wait_done("t6d", 20);
    check_val("t6d_nwr", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) check_val("t6d_last_cyc", 32'(log_q[2].cyc), 32'(e0 + 2));
    do_ack();
`else
    // Vector 7: 4-sample averaging of constant channels.
    clear_log();
    const_mode = 1'b1;
    const_val  = 32'h0000_FF0A;
    tick();
    arm_cfg(16'd0, 11'd3, 8'd2, 4'h3);
    pulse_trig();
    wait_done("t7", 40);
    check_val("t7_nwr", 32'(log_q.size()), 32'd3);
    for (int k = 0; k < log_q.size() && k < 3; k++) begin
      check_val($sformatf("t7_data%0d", k), log_q[k].data, 32'h0000_FF0A);
      check_val($sformatf("t7_cyc%0d", k), 32'(log_q[k].cyc), 32'(e0 + 3 + 4 * k));
    end
    do_ack();
    const_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
